// File: rtl/mina_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, IMEM request/grant/response channel,
// IF/ID valid/ready channel and status outputs.
interface mina_fetch_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  logic                       redirect_req;
  logic [XLEN-1:0]            redirect_ia;
  logic                       imem_req;
  logic [XLEN-1:0]            imem_addr;
  logic                       imem_gnt;
  logic                       imem_rvalid;
  logic [XLEN-1:0]            imem_rdata;
  logic                       if_valid;
  logic                       if_ready;
  logic [XLEN-1:0]            if_ir;
  logic [XLEN-1:0]            if_ia;
  logic [XLEN-1:0]            if_ia_plus_4;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic                       err_unexp;

  // Fetch unit side
  modport master (
    input  redirect_req, redirect_ia,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid,
    input  if_ready,
    output if_ir, if_ia, if_ia_plus_4, occupancy, err_unexp
  );

  // Environment side (EX, IMEM, IF/ID)
  modport slave (
    output redirect_req, redirect_ia,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_ir, if_ia, if_ia_plus_4, occupancy, err_unexp
  );
endinterface

// File: rtl/mina_fetch_unit.sv
// MINA instruction-fetch front end: credit-limited IMEM requests, in-order
// address tags, prefetch queue towards IF/ID, redirect flush with discard
// of stale in-flight responses.
module mina_fetch_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] INITIAL_IA = '0
) (
  input logic               clk,
  input logic               rst_n,
  mina_fetch_unit_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [XLEN-1:0] ia;
    logic [XLEN-1:0] ir;
  } entry_t;

  logic [XLEN-1:0] fetch_ia_q, fetch_ia_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic            err_q, err_d;
  entry_t          q_mem_q [DEPTH];
  entry_t          q_mem_d [DEPTH];
  logic [PW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  logic [XLEN-1:0] tag_mem_q [DEPTH];
  logic [XLEN-1:0] tag_mem_d [DEPTH];
  logic [PW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [SW-1:0] credit_sum;
  logic          req, grant, rsp_drop, rsp_take, rsp_unexp;
  logic          valid, push, pop;
  entry_t        head;

  // Handshake decode: credit check, response classification, queue pop/push
  always_comb begin
    credit_sum = SW'(occ_q) + SW'(out_q) + SW'(disc_q);
    // rst_n gating keeps imem_req low while reset is held
    req        = rst_n && !bus.redirect_req && (credit_sum < SW'(DEPTH));
    grant      = req && bus.imem_gnt;
    rsp_drop   = bus.imem_rvalid && (disc_q != '0);
    rsp_take   = bus.imem_rvalid && (disc_q == '0) && (out_q != '0);
    rsp_unexp  = bus.imem_rvalid && (disc_q == '0) && (out_q == '0);
    valid      = (occ_q != '0) && !bus.redirect_req;
    pop        = valid && bus.if_ready;
    push       = rsp_take && !bus.redirect_req;
    head       = q_mem_q[q_rd_q];
  end

  // Output drive from fetch pointer and queue head
  always_comb begin
    bus.imem_req     = req;
    bus.imem_addr    = fetch_ia_q;
    bus.if_valid     = valid;
    bus.if_ir        = head.ir;
    bus.if_ia        = head.ia;
    bus.if_ia_plus_4 = head.ia + XLEN'(4);
    bus.occupancy    = occ_q;
    bus.err_unexp    = err_q;
  end

  // Next state: issue, response bookkeeping, queue update, redirect flush
  always_comb begin
    fetch_ia_d = fetch_ia_q;
    occ_d      = occ_q;
    out_d      = out_q;
    disc_d     = disc_q;
    q_mem_d    = q_mem_q;
    q_rd_d     = q_rd_q;
    q_wr_d     = q_wr_q;
    tag_mem_d  = tag_mem_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    err_d      = err_q | rsp_unexp;

    if (grant) begin
      tag_mem_d[tag_wr_q] = fetch_ia_q;
      tag_wr_d            = tag_wr_q + PW'(1);
      fetch_ia_d          = fetch_ia_q + XLEN'(4);
    end
    // Tags are popped for dropped responses too, so the tag FIFO is never
    // flushed on redirect; it drains as the discarded responses arrive.
    if (rsp_drop || rsp_take) begin
      tag_rd_d = tag_rd_q + PW'(1);
    end

    if (bus.redirect_req) begin
      fetch_ia_d = bus.redirect_ia;
      out_d      = '0;
      disc_d     = disc_q + out_q - CW'(rsp_drop) - CW'(rsp_take);
      occ_d      = '0;
      q_rd_d     = '0;
      q_wr_d     = '0;
    end else begin
      out_d  = out_q + CW'(grant) - CW'(rsp_take);
      disc_d = disc_q - CW'(rsp_drop);
      if (push) begin
        q_mem_d[q_wr_q] = entry_t'{ia: tag_mem_q[tag_rd_q], ir: bus.imem_rdata};
        q_wr_d          = q_wr_q + PW'(1);
      end
      if (pop) begin
        q_rd_d = q_rd_q + PW'(1);
      end
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_ia_q <= INITIAL_IA;
      occ_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      err_q      <= 1'b0;
      q_mem_q    <= '{default: '0};
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      tag_mem_q  <= '{default: '0};
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_ia_q <= fetch_ia_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      err_q      <= err_d;
      q_mem_q    <= q_mem_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      tag_mem_q  <= tag_mem_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end
endmodule

// File: tb/tb_mina_fetch_unit.sv
// Testbench for mina_fetch_unit: vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_mina_fetch_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mina_fetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  mina_fetch_unit #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INITIAL_IA(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Instruction word stored at a given address in the emulated IMEM
  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic [31:0] ria, input int g, input int rv,
                       input logic [31:0] rd, input int rdy);
    bus.redirect_req = (r != 0);
    bus.redirect_ia  = ria;
    bus.imem_gnt     = (g != 0);
    bus.imem_rvalid  = (rv != 0);
    bus.imem_rdata   = rd;
    bus.if_ready     = (rdy != 0);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          redir;
    logic [31:0] ria;
    int          gnt;
    int          rv;
    logic [31:0] rdata;
    int          rdy;
    int          e_req;
    logic [31:0] e_addr;
    int          e_valid;
    logic [31:0] e_ia;
    int          e_occ;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(int r, logic [31:0] ria, int g, int rv, logic [31:0] rd, int rdy,
                              int e_req, logic [31:0] e_addr, int e_valid, logic [31:0] e_ia,
                              int e_occ);
    vec_t v;
    v.redir = r; v.ria = ria; v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ia = e_ia; v.e_occ = e_occ;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { logic [31:0] ia; logic [31:0] ir; } ent_t;

  infl_t       inflq[$];
  ent_t        outq[$];
  logic [31:0] mpend[$];
  logic [31:0] m_fetch;
  bit          m_err;

  task automatic run_random(input int n);
    int          r, g, rv, rdy, e_req, e_valid;
    logic [31:0] ria, rd;
    infl_t       e;
    inflq.delete(); outq.delete(); mpend.delete();
    m_fetch = 32'h0;
    m_err   = 1'b0;
    for (int c = 0; c < n; c++) begin
      r   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      ria = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      g   = ($urandom_range(0, 9) < 7) ? 1 : 0;
      rv  = ((mpend.size() != 0) && ($urandom_range(0, 9) < 6)) ? 1 : 0;
      rd  = (rv != 0) ? mw(mpend[0]) : $urandom;
      rdy = ($urandom_range(0, 9) < 6) ? 1 : 0;
      drive(r, ria, g, rv, rd, rdy);

      e_req   = ((outq.size() + inflq.size() < DEPTH) && (r == 0)) ? 1 : 0;
      e_valid = ((outq.size() != 0) && (r == 0)) ? 1 : 0;
      chk("rnd_req", 32'(bus.imem_req), 32'(e_req));
      if (e_req != 0) chk("rnd_addr", bus.imem_addr, m_fetch);
      chk("rnd_valid", 32'(bus.if_valid), 32'(e_valid));
      if (e_valid != 0) begin
        chk("rnd_ia", bus.if_ia, outq[0].ia);
        chk("rnd_ir", bus.if_ir, outq[0].ir);
        chk("rnd_ia4", bus.if_ia_plus_4, outq[0].ia + 32'd4);
      end
      chk("rnd_occ", 32'(bus.occupancy), 32'(outq.size()));
      chk("rnd_err", 32'(bus.err_unexp), 32'(m_err));

      // emulated IMEM: in-order responses for whatever the DUT was granted
      if (rv != 0) void'(mpend.pop_front());
      if (bus.imem_req && (g != 0)) mpend.push_back(bus.imem_addr);

      // model update for this clock edge
      if ((e_valid != 0) && (rdy != 0)) void'(outq.pop_front());
      if (rv != 0) begin
        if (inflq.size() == 0) m_err = 1'b1;
        else begin
          e = inflq.pop_front();
          if (!e.stale && (r == 0)) outq.push_back('{e.addr, mw(e.addr)});
        end
      end
      if (r != 0) begin
        outq.delete();
        foreach (inflq[i]) inflq[i].stale = 1'b1;
        m_fetch = ria;
      end else if ((e_req != 0) && (g != 0)) begin
        inflq.push_back('{m_fetch, 1'b0});
        m_fetch = m_fetch + 32'd4;
      end
      tick();
    end
  endtask

  initial begin
    // ---- reset state ----
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    tick();
    tick();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_err", 32'(bus.err_unexp), 32'd0);
    rst_n = 1'b1;

    // ---- streaming from reset: one grant and one instruction per cycle ----
    vecs[0] = mk(0, 0, 1, 0, 0,            1, 1, 32'h00, 0, 32'h00, 0);
    vecs[1] = mk(0, 0, 1, 1, mw(32'h00),   1, 1, 32'h04, 0, 32'h00, 0);
    vecs[2] = mk(0, 0, 1, 1, mw(32'h04),   1, 1, 32'h08, 1, 32'h00, 1);
    vecs[3] = mk(0, 0, 1, 1, mw(32'h08),   1, 1, 32'h0C, 1, 32'h04, 1);
    vecs[4] = mk(0, 0, 1, 1, mw(32'h0C),   1, 1, 32'h10, 1, 32'h08, 1);
    vecs[5] = mk(0, 0, 0, 1, mw(32'h10),   1, 1, 32'h14, 1, 32'h0C, 1);
    vecs[6] = mk(0, 0, 0, 0, 0,            1, 1, 32'h14, 1, 32'h10, 1);
    vecs[7] = mk(0, 0, 0, 0, 0,            0, 1, 32'h14, 0, 32'h00, 0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].redir, vecs[i].ria, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
      chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req != 0) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(bus.if_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid != 0) begin
        chk($sformatf("vec%0d_ia", i), bus.if_ia, vecs[i].e_ia);
        chk($sformatf("vec%0d_ir", i), bus.if_ir, mw(vecs[i].e_ia));
        chk($sformatf("vec%0d_ia4", i), bus.if_ia_plus_4, vecs[i].e_ia + 32'd4);
      end
      chk($sformatf("vec%0d_occ", i), 32'(bus.occupancy), 32'(vecs[i].e_occ));
      tick();
    end

    // ---- fill with ready=0: exactly DEPTH grants, then drain in order ----
    do_reset();
    for (int c = 0; c < 7; c++) begin
      logic [31:0] a;
      a = 32'(c - 1) * 32'd4;
      drive(0, 0, 1, ((c >= 1) && (c <= 4)) ? 1 : 0, mw(a), 0);
      if (c < 4) begin
        chk("fill_req", 32'(bus.imem_req), 32'd1);
        chk("fill_addr", bus.imem_addr, 32'(c) * 32'd4);
      end else begin
        chk("fill_req_off", 32'(bus.imem_req), 32'd0);
      end
      if (c >= 5) begin
        chk("fill_occ", 32'(bus.occupancy), 32'd4);
        chk("fill_head", bus.if_ia, 32'h0);
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, (c == 1) ? 1 : 0, 0, 0, 1);
      chk("drain_valid", 32'(bus.if_valid), 32'd1);
      chk("drain_ia", bus.if_ia, 32'(c) * 32'd4);
      chk("drain_ir", bus.if_ir, mw(32'(c) * 32'd4));
      if (c == 1) begin
        chk("resume_req", 32'(bus.imem_req), 32'd1);
        chk("resume_addr", bus.imem_addr, 32'h10);
      end
      tick();
    end

    // ---- redirect with 3 outstanding: stale responses discarded ----
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 0, 0, 1);
      chk("redir_pre_addr", bus.imem_addr, 32'(c) * 32'd4);
      tick();
    end
    drive(1, 32'h100, 1, 0, 0, 1);
    chk("redir_req_off", 32'(bus.imem_req), 32'd0);
    tick();
    drive(0, 0, 1, 1, mw(32'h0), 1);
    chk("redir_tgt_addr", bus.imem_addr, 32'h100);
    chk("redir_tgt_req", 32'(bus.imem_req), 32'd1);
    tick();
    drive(0, 0, 0, 1, mw(32'h4), 1);
    chk("redir_stale1", 32'(bus.if_valid), 32'd0);
    tick();
    drive(0, 0, 0, 1, mw(32'h8), 1);
    chk("redir_stale2", 32'(bus.if_valid), 32'd0);
    tick();
    drive(0, 0, 0, 1, mw(32'h100), 1);
    chk("redir_stale3", 32'(bus.if_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("redir_new_valid", 32'(bus.if_valid), 32'd1);
    chk("redir_new_ia", bus.if_ia, 32'h100);
    chk("redir_new_ir", bus.if_ir, mw(32'h100));
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("redir_after_occ", 32'(bus.occupancy), 32'd0);
    chk("redir_no_err", 32'(bus.err_unexp), 32'd0);
    tick();

    // ---- grant stall: address held, single grant advances by 4 ----
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_addr", bus.imem_addr, 32'h0);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    chk("stall_gnt_addr", bus.imem_addr, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stall_next_addr", bus.imem_addr, 32'h4);
    tick();

    // ---- redirect coincident with rvalid and ready ----
    do_reset();
    drive(0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 1, 1, mw(32'h0), 0);
    tick();
    drive(0, 0, 1, 1, mw(32'h4), 0);
    chk("coin_addr8", bus.imem_addr, 32'h8);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    chk("coin_occ2", 32'(bus.occupancy), 32'd2);
    chk("coin_addrC", bus.imem_addr, 32'hC);
    tick();
    drive(1, 32'h200, 1, 1, mw(32'h8), 1);
    chk("coin_valid_off", 32'(bus.if_valid), 32'd0);
    chk("coin_req_off", 32'(bus.imem_req), 32'd0);
    tick();
    drive(0, 0, 1, 1, mw(32'hC), 1);
    chk("coin_occ0", 32'(bus.occupancy), 32'd0);
    chk("coin_valid0", 32'(bus.if_valid), 32'd0);
    chk("coin_addr", bus.imem_addr, 32'h200);
    tick();
    drive(0, 0, 0, 1, mw(32'h200), 1);
    chk("coin_drop", 32'(bus.if_valid), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    chk("coin_new_valid", 32'(bus.if_valid), 32'd1);
    chk("coin_new_ia", bus.if_ia, 32'h200);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("coin_once", 32'(bus.if_valid), 32'd0);

    // ---- unexpected response: sticky error ----
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("unexp_before", 32'(bus.err_unexp), 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 1, 0, 0, 0);
      chk("unexp_sticky", 32'(bus.err_unexp), 32'd1);
      tick();
    end

    // ---- reset mid-stream, then a response for a pre-reset request ----
    rst_n = 1'b0;
    drive(0, 0, 1, 0, 0, 1);
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("mid_rst_occ", 32'(bus.occupancy), 32'd0);
    chk("mid_rst_valid", 32'(bus.if_valid), 32'd0);
    chk("mid_rst_err", 32'(bus.err_unexp), 32'd0);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, mw(32'h0), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("post_rst_err", 32'(bus.err_unexp), 32'd1);
    chk("post_rst_valid", 32'(bus.if_valid), 32'd0);
    tick();

    // ---- randomized run against the reference model ----
    do_reset();
    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mina_fetch_unit.md
Name: mina_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the MINA pipeline.
- Replaces the single-cycle IA register and direct IMEM read with a request/grant/response IMEM interface that tolerates variable latency.
- Keeps up to DEPTH fetches in flight or buffered in a prefetch queue and presents instructions to IF/ID through a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, prefetch queue entries and maximum in-flight plus buffered fetches; power of two, >= 2.
- INITIAL_IA, 32'h0, fetch address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- redirect_req  in  1  branch/flush request from EX
- redirect_ia  in  XLEN  target address, sampled when redirect_req=1
- imem_req  out  1  fetch request, level signal
- imem_addr  out  XLEN  fetch address, valid while imem_req=1
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  XLEN  instruction word
- if_valid  out  1  queue head valid
- if_ready  in  1  consumer accepts head
- if_ir  out  XLEN  head instruction
- if_ia  out  XLEN  head instruction address
- if_ia_plus_4  out  XLEN  if_ia + 4, modulo 2^XLEN
- occupancy  out  $clog2(DEPTH+1)  queue entry count
- err_unexp  out  1  sticky: rvalid received with nothing outstanding

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - fetch_ia = INITIAL_IA.
  - Queue empty; occupancy = 0.
  - Outstanding count = 0; discard count = 0.
  - err_unexp = 0; imem_req = 0; if_valid = 0.
- Reset mid-operation: all state is dropped; any later rvalid for pre-reset requests sets err_unexp.
- Credit rule:
  - imem_req = (occupancy + outstanding + discard) < DEPTH && !redirect_req.
  - imem_addr = fetch_ia.
- Issue:
  - On imem_req && imem_gnt: outstanding += 1, fetch_ia += 4 (wraps), and fetch_ia is pushed into an address tag FIFO of DEPTH entries.
  - While imem_req=1 and imem_gnt=0, imem_addr is held stable.
  - A request can be withdrawn only by redirect_req.
- Response:
  - On imem_rvalid with discard > 0: discard -= 1, data dropped, tag FIFO popped.
  - On imem_rvalid with discard = 0 and outstanding > 0: outstanding -= 1, tag popped, {tag, imem_rdata} pushed to the queue. The new entry is visible on if_* the next cycle (one-cycle rvalid -> if_valid latency).
  - On imem_rvalid with outstanding = 0 and discard = 0: response ignored, err_unexp <= 1.
- The queue never overflows: the credit rule guarantees a free slot for every response.
- Output side:
  - if_valid = (occupancy != 0) && !redirect_req.
  - if_ir, if_ia and if_ia_plus_4 are taken from the queue head.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
- Redirect (redirect_req=1 at a clk edge), with precedence over everything else that cycle:
  - Queue is flushed; any pop that cycle is void.
  - discard <= discard + outstanding − (1 if an rvalid is consumed this cycle); outstanding <= 0.
  - fetch_ia <= redirect_ia.
  - No grant counts that cycle because imem_req=0.
  - Fetching resumes next cycle from redirect_ia, subject to the credit rule.
- Back-to-back redirects accumulate discard correctly; the last target wins.
- Counters are sized to hold DEPTH and never wrap.

Test Plan:
- Reset release; gnt=1 always; rvalid one cycle after each grant; ready=1 -> imem_addr 0,4,8,... on consecutive cycles; first if_valid two cycles after the first grant with if_ia=0, if_ia_plus_4=4; one instruction per cycle thereafter.
- DEPTH=4, ready=0 -> exactly 4 grants (addr 0..0xC), then imem_req=0 and occupancy=4 held; raise ready -> heads 0,4,8,0xC popped in order and issue resumes at 0x10.
- 3 requests outstanding, redirect_req=1 with redirect_ia=0x100 -> next 3 rvalids dropped; next accepted instruction has if_ia=0x100; no stale data appears on if_*.
- gnt held low for 5 cycles -> imem_req=1 and imem_addr constant throughout; a single grant advances the address by exactly 4.
- redirect coincident with rvalid and with if_valid && if_ready -> queue empty next cycle, discard equals outstanding−1, the popped entry is not delivered twice.
- rvalid with nothing outstanding -> err_unexp=1, stays set until rst_n=0; a reset asserted mid-stream returns all outputs to reset values next cycle.
